// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises bitstream words LSB-first into a ccff chain.
// Optional readback verify pass: define CCFF_READBACK_CHECK_EN.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 48,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              abort,
   input  logic              s_valid,
   input  logic [WORD_W-1:0] s_data,
   output logic              s_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              cfg_clk_en,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
   localparam int WW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CHAIN_LEN - 1);
   localparam logic [WW-1:0] WBIT_LAST = WW'(WORD_W - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;

   logic [2:0]        state;
   logic [WORD_W-1:0] word;
   logic [CW-1:0]     bit_cnt;
   logic [WW-1:0]     wbit;
   logic              in_shift;
   logic              in_verify;
   logic              shift_bit;
   logic              vbit;
   logic              last_bit;

   assign in_shift  = (state == S_SHIFT);
   assign shift_bit = word[wbit];
   assign last_bit  = (bit_cnt == BIT_LAST);

`ifdef CCFF_READBACK_CHECK_EN
   localparam logic [2:0] S_VERIFY = 3'd4;

   logic [CHAIN_LEN-1:0] shadow;

   assign in_verify = (state == S_VERIFY);
   assign vbit      = shadow[bit_cnt];

   // Shadow mirrors the chain so the verify pass can re-insert each bit.
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         shadow <= '0;
      end else if (in_shift) begin
         shadow[bit_cnt] <= shift_bit;
      end
   end
`else
   logic unused_tail;

   assign unused_tail = ccff_tail;
   assign in_verify   = 1'b0;
   assign vbit        = 1'b0;
`endif

   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         state   <= S_IDLE;
         word    <= '0;
         bit_cnt <= '0;
         wbit    <= '0;
         err     <= 1'b0;
      end else if (abort && (state != S_IDLE)) begin
         state <= S_IDLE;
         err   <= 1'b1;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_FETCH;
                  err     <= 1'b0;
                  bit_cnt <= '0;
               end
            end
            S_FETCH: begin
               if (s_valid) begin
                  word  <= s_data;
                  wbit  <= '0;
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               wbit <= wbit + WW'(1);
               if (last_bit) begin
                  bit_cnt <= '0;
`ifdef CCFF_READBACK_CHECK_EN
                  state   <= S_VERIFY;
`else
                  state   <= S_DONE;
`endif
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
                  if (wbit == WBIT_LAST) begin
                     state <= S_FETCH;
                  end
               end
            end
`ifdef CCFF_READBACK_CHECK_EN
            S_VERIFY: begin
               if (ccff_tail != vbit) begin
                  err <= 1'b1;
               end
               if (last_bit) begin
                  bit_cnt <= '0;
                  state   <= S_DONE;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
`endif
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign s_ready    = (state == S_FETCH);
   assign busy       = (state != S_IDLE);
   assign cfg_clk_en = in_shift | in_verify;
   assign ccff_head  = in_shift ? shift_bit : (in_verify & vbit);
   assign done       = (state == S_DONE) & ~err;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed/random loads against a behavioural chain model.
// Expected latencies follow CCFF_READBACK_CHECK_EN when defined.
module tb_ccff_chain_loader;

   localparam int CL = 48;
   localparam int W  = 8;
   localparam int NW = (CL + W - 1) / W;
   localparam int CLB = 20;
   localparam int NWB = (CLB + W - 1) / W;
`ifdef CCFF_READBACK_CHECK_EN
   localparam int LAT  = NW * (W + 1) + 1 + CL;
   localparam int EN   = 2 * CL;
   localparam int LATB = NWB + CLB + 1 + CLB;
   localparam int ENB  = 2 * CLB;
`else
   localparam int LAT  = NW * (W + 1) + 1;
   localparam int EN   = CL;
   localparam int LATB = NWB + CLB + 1;
   localparam int ENB  = CLB;
`endif

   logic prog_clk = 1'b0;
   logic pReset;
   logic start, abort, s_valid;
   logic [W-1:0] s_data;
   logic s_ready, ccff_head, ccff_tail, cfg_clk_en, busy, done, err;

   logic start_b, abort_b, s_valid_b;
   logic [W-1:0] s_data_b;
   logic s_ready_b, ccff_head_b, ccff_tail_b, cfg_clk_en_b;
   logic busy_b, done_b, err_b;

   int checks = 0;
   int errors = 0;

   logic [CL-1:0]  chain;
   logic [CLB-1:0] chain_b;
   int en_total = 0;
   int en_total_b = 0;
   int en_base = 0;
   int en_base_b = 0;
   bit inj = 1'b0;

   logic [W-1:0] words [NW];
   logic [W-1:0] wb [4];
   int widx;
   int done_t, end_t;
   bit noen_ok;
   logic head_q [$];

   always #5 prog_clk = ~prog_clk;

   ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(W)) u_dut (
      .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .ccff_head(ccff_head), .ccff_tail(ccff_tail), .cfg_clk_en(cfg_clk_en),
      .busy(busy), .done(done), .err(err));

   ccff_chain_loader #(.CHAIN_LEN(CLB), .WORD_W(W)) u_dut_b (
      .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .abort(abort_b),
      .s_valid(s_valid_b), .s_data(s_data_b), .s_ready(s_ready_b),
      .ccff_head(ccff_head_b), .ccff_tail(ccff_tail_b),
      .cfg_clk_en(cfg_clk_en_b), .busy(busy_b), .done(done_b), .err(err_b));

   // Chain models: head enters at the top, tail is the lowest flop.
   always @(posedge prog_clk) begin
      if (cfg_clk_en) begin
         chain    <= {ccff_head, chain[CL-1:1]};
         en_total <= en_total + 1;
      end
      if (cfg_clk_en_b) begin
         chain_b    <= {ccff_head_b, chain_b[CLB-1:1]};
         en_total_b <= en_total_b + 1;
      end
   end

   assign ccff_tail = chain[0] ^
      (inj && cfg_clk_en && ((en_total - en_base) == CL + 17));
   assign ccff_tail_b = chain_b[0];

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_load(input int stall_at, input int stall_len,
                           input int abort_at, input int rst_at,
                           input int spt);
      int left;
      bit hs;
      left = stall_len;
      hs = 1'b0;
      widx = 0;
      head_q.delete();
      done_t = -1;
      end_t = -1;
      noen_ok = 1'b1;
      @(negedge prog_clk);
      en_base = en_total;
      start = 1'b1;
      abort = 1'b0;
      s_valid = 1'b1;
      s_data = words[0];
      for (int t = 1; t <= 400; t++) begin
         @(negedge prog_clk);
         if (hs) widx++;
         start = (t == spt);
         abort = 1'b0;
         if (cfg_clk_en && head_q.size() < CL) head_q.push_back(ccff_head);
         if (cfg_clk_en && s_ready) noen_ok = 1'b0;
         if (done) begin
            done_t = t;
            end_t = t;
            return;
         end
         if (!busy) begin
            end_t = t;
            return;
         end
         if (cfg_clk_en && widx == abort_at) begin
            abort = 1'b1;
            return;
         end
         if (cfg_clk_en && widx == rst_at) begin
            pReset = 1'b0;
            #1;
            return;
         end
         s_valid = (widx < NW) && !(widx == stall_at && left > 0);
         s_data = (widx < NW) ? words[widx] : '0;
         if (s_ready && !s_valid) left--;
         hs = s_ready && s_valid;
      end
   endtask

   task automatic check_load(input string tag, input int lat);
      logic [CL-1:0] got;
      logic [CL-1:0] exp;
      got = '0;
      for (int i = 0; i < CL; i++) exp[i] = words[i / W][i % W];
      for (int i = 0; i < head_q.size(); i++) got[i] = head_q[i];
      check({tag, ".done_t"}, 64'(done_t), 64'(lat));
      check({tag, ".en_cycles"}, 64'(en_total - en_base), 64'(EN));
      check({tag, ".nhead"}, 64'(head_q.size()), 64'(CL));
      check({tag, ".head"}, 64'(got), 64'(exp));
      check({tag, ".err"}, 64'(err), 64'(0));
      check({tag, ".no_en_in_fetch"}, 64'(noen_ok), 64'(1));
      @(negedge prog_clk);
      start = 1'b0;
      check({tag, ".after"}, 64'({busy, done}), 64'(0));
      check({tag, ".chain"}, 64'(chain), 64'(exp));
   endtask

   task automatic rand_words();
      for (int i = 0; i < NW; i++) words[i] = W'($urandom);
   endtask

   task automatic run_small();
      int acc, nb, dt;
      bit hs;
      logic [CLB-1:0] got, exp;
      acc = 0; nb = 0; dt = -1; hs = 1'b0; got = '0;
      for (int i = 0; i < 4; i++) wb[i] = W'($urandom);
      @(negedge prog_clk);
      en_base_b = en_total_b;
      start_b = 1'b1;
      s_valid_b = 1'b1;
      s_data_b = wb[0];
      for (int t = 1; t <= 200; t++) begin
         @(negedge prog_clk);
         start_b = 1'b0;
         if (hs) acc++;
         if (cfg_clk_en_b && nb < CLB) begin
            got[nb] = ccff_head_b;
            nb++;
         end
         if (done_b) begin
            dt = t;
            break;
         end
         if (!busy_b) break;
         s_data_b = wb[(acc < 4) ? acc : 3];
         hs = s_ready_b;
      end
      for (int i = 0; i < CLB; i++) exp[i] = wb[i / W][i % W];
      check("small.words", 64'(acc), 64'(NWB));
      check("small.done_t", 64'(dt), 64'(LATB));
      check("small.en_cycles", 64'(en_total_b - en_base_b), 64'(ENB));
      check("small.nhead", 64'(nb), 64'(CLB));
      check("small.head", 64'(got), 64'(exp));
      check("small.chain", 64'(chain_b), 64'(exp));
   endtask

   initial begin
      bit seen;
      pReset = 1'b0;
      start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
      start_b = 1'b0; abort_b = 1'b0; s_valid_b = 1'b0; s_data_b = '0;

      repeat (2) @(negedge prog_clk);
      check("reset.outs",
            64'({s_ready, ccff_head, cfg_clk_en, busy, done, err}), 64'(0));
      pReset = 1'b1;
      @(negedge prog_clk);
      abort = 1'b1;
      @(negedge prog_clk);
      abort = 1'b0;
      check("idle_abort", 64'({busy, err, cfg_clk_en}), 64'(0));

      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
      words[3] = 8'h00; words[4] = 8'h81; words[5] = 8'h7E;
      run_load(-1, 0, -1, -1, 0);
      check_load("fixed", LAT);

      rand_words();
      run_load(3, 5, -1, -1, 20);
      check_load("stall", LAT + 5);

      rand_words();
      run_load(-1, 0, 2, -1, 0);
      @(negedge prog_clk);
      abort = 1'b0;
      check("abort.outs", 64'({busy, err, cfg_clk_en, done}), 64'(4'b0100));
      seen = 1'b0;
      repeat (70) begin
         @(negedge prog_clk);
         if (done || busy) seen = 1'b1;
      end
      check("abort.quiet", 64'({seen, err}), 64'(2'b01));

      start = 1'b1;
      abort = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_idle", 64'({busy, err}), 64'(2'b10));
      abort = 1'b1;
      @(negedge prog_clk);
      abort = 1'b0;
      check("abort_fetch", 64'({busy, err}), 64'(2'b01));

      rand_words();
      run_load(-1, 0, -1, -1, 0);
      check_load("reload", LAT);

      rand_words();
      run_load(-1, 0, -1, 4, 0);
      check("rst.outs",
            64'({s_ready, ccff_head, cfg_clk_en, busy, done, err}), 64'(0));
      @(negedge prog_clk);
      pReset = 1'b1;
      rand_words();
      run_load(-1, 0, -1, -1, 0);
      check_load("post_rst", LAT);

      run_small();

`ifdef CCFF_READBACK_CHECK_EN
      rand_words();
      inj = 1'b1;
      run_load(-1, 0, -1, -1, 0);
      check("inj.done_t", 64'(done_t), 64'(-1));
      check("inj.end_t", 64'(end_t), 64'(LAT + 1));
      check("inj.err", 64'(err), 64'(1));
      inj = 1'b0;
      rand_words();
      run_load(-1, 0, -1, -1, 0);
      check_load("verify_ok", LAT);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
